lbfifo_rd: RTL and testbench
============================

Name: lbfifo_rd

Overview:
- Read-side counterpart to the team's write-driven line-buffer memory.
- Buffers a stream of words pushed by a producer (wen/wdata).
- Exposes a consumer-paced read port (ren/rdata/valid) with a fill threshold, so the consumer sees data only once a full line segment is buffered.
- Sits between a pixel producer and a stencil/consumer stage that must stall independently of the producer.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 64, storage entries; power of two, >= 2.
- THRESH, 8, occupancy that arms the read side; 1 <= THRESH <= DEPTH.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- wdata  input  WIDTH  write data.
- wen  input  1  write request.
- full  output  1  high when count == DEPTH.
- ren  input  1  read/pop request; honoured only while valid == 1.
- rdata  output  WIDTH  head-of-queue word, combinational from storage.
- valid  output  1  read side armed (DRAIN state).
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky dropped-write flag (see Optional Feature).

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RESET). All state updates on the rising edge of CLK.
- Reset values:
  - waddr = 0, raddr = 0, count = 0.
  - State FILL, valid = 0, full = 0, overflow = 0.
  - Storage contents are not reset; rdata is don't-care while valid = 0.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
- pop = ren & valid.
- push = wen & (!full | pop). A write while full is accepted if a pop occurs in the same cycle.
- Push: store wdata at waddr, then waddr+1.
- Pop: raddr+1.
- count_next = count + push - pop.
- full is registered and equals (count_next == DEPTH).
- rdata = mem[raddr]: zero-latency head word, which changes the cycle after a pop.
- Write-to-read: a word written at edge N is readable from mem no earlier than after edge N.
- State machine (valid = state):
  - FILL -> DRAIN when count_next >= THRESH. valid rises the cycle after the THRESH-th word is written.
  - FILL holds otherwise. ren is ignored in FILL and does not change count.
  - DRAIN -> FILL when count_next == 0. valid falls the cycle after the last pop.
  - DRAIN holds otherwise. Writes continue during DRAIN, and the consumer may pop whenever count > 0.
- Simultaneous push and pop in DRAIN: count unchanged, pointers both advance.
- Push and pop on the last word in the same cycle: count stays 1, remain in DRAIN.
- Reset asserted mid-operation discards all buffered data; state as above on the next cycle.

Optional Feature:
- Macro LBFIFO_RD_OVERFLOW_EN.
- When defined:
  - overflow is set on the edge where wen & full & !pop.
  - It is sticky until RESET.
  - The write is still dropped and no state changes.
- When undefined: overflow is tied to 0 and the detect logic is absent. Dropped-write behaviour is otherwise identical.

Test Plan:
1. After reset, write 0x1000..0x1007 on 8 consecutive cycles, ren = 0 -> valid stays 0 through the edge of the 7th write; valid = 1 and count = 8 after the 8th; rdata = 0x1000.
2. From scenario 1, hold ren = 1 for 8 cycles -> rdata steps 0x1000..0x1007; count reaches 0 and valid = 0 after the 8th pop; a 9th ren has no effect.
3. Write 64 words 0x0000..0x003F, then wen with 0xDEAD, ren = 0 -> full = 1, count = 64, 0xDEAD dropped, rdata = 0x0000; overflow = 1 only with macro defined.
4. While full and valid, wen = ren = 1 with wdata = 0xBEEF -> count stays 64, full stays 1; after 64 further pops, the last word read is 0xBEEF.
5. Write 5 words and pulse ren for 3 cycles -> valid = 0, count = 5, raddr unchanged. Then write 3 more -> valid = 1, rdata = first word.
6. Stream 200 words with random wen/ren (ren ~60%) -> read order matches write order across pointer wrap. Assert RESET mid-stream -> next cycle count = 0, valid = 0, full = 0, overflow = 0.

Source files
------------

// File: rtl/lbfifo_rd.sv
`default_nettype none
// ============================================================================
// Module   : lbfifo_rd
// Brief    : Line-buffer FIFO whose read side arms once THRESH words are
//            buffered and drains until empty. Optional sticky overflow flag
//            enabled by defining LBFIFO_RD_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lbfifo_rd #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 64,
    parameter int THRESH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     wen,
    output logic                     full,
    input  logic                     ren,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            pop, push;

    logic [WIDTH-1:0] mem [DEPTH];

    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign pop  = ren & (state_q == DRAIN);
    assign push = wen & (~full_q | pop);

    always_comb begin
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        full_d  = (count_d == CW'(DEPTH));
        state_d = state_q;
        if (push) begin
            waddr_d = waddr_q + AW'(1);
        end
        if (pop) begin
            raddr_d = raddr_q + AW'(1);
        end
        case (state_q)
            FILL:    if (count_d >= CW'(THRESH)) state_d = DRAIN;
            DRAIN:   if (count_d == '0)          state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= FILL;
            waddr_q <= '0;
            raddr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Storage is deliberately left unreset; rdata is meaningless until valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[waddr_q] <= wdata;
        end
    end

`ifdef LBFIFO_RD_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow_q <= 1'b0;
        end else if (wen & full_q & ~pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign rdata = mem[raddr_q];
    assign valid = (state_q == DRAIN);
    assign full  = full_q;
    assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_lbfifo_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_lbfifo_rd
// Brief    : Self-checking bench for lbfifo_rd: occupancy model plus a data
//            scoreboard checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lbfifo_rd;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 64;
    localparam int THRESH = 8;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic [WIDTH-1:0]  wdata = '0;
    logic              wen = 1'b0;
    logic              ren = 1'b0;
    logic              full;
    logic [WIDTH-1:0]  rdata;
    logic              valid;
    logic [6:0]        count;
    logic              overflow;

    lbfifo_rd #(.WIDTH(WIDTH), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .CLK(CLK), .RESET(RESET), .wdata(wdata), .wen(wen), .full(full),
        .ren(ren), .rdata(rdata), .valid(valid), .count(count),
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy/arming rules plus an ordered list of accepted words.
    int              m_count = 0;
    bit              m_armed = 0;
    bit              m_full  = 0;
    bit              m_ovf   = 0;
    bit              started = 0;
    int              nw      = 0;
    logic [WIDTH-1:0] sb[$];

    always @(posedge CLK) begin
        bit m_pop, m_push;
        if (RESET) begin
            m_count = 0; m_armed = 0; m_full = 0; m_ovf = 0;
            sb.delete();
            started = 1;
        end else begin
            m_pop  = ren && m_armed;
            m_push = wen && (!m_full || m_pop);
            if (m_push) begin
                sb.push_back(wdata);
                nw++;
            end
`ifdef LBFIFO_RD_OVERFLOW_EN
            if (wen && m_full && !m_pop) m_ovf = 1;
`endif
            m_count = m_count + int'(m_push) - int'(m_pop);
            m_full  = (m_count == DEPTH);
            if (!m_armed && m_count >= THRESH) m_armed = 1;
            else if (m_armed && m_count == 0)  m_armed = 0;
        end
    end

    // Monitor: status every cycle, data whenever a pop is about to be taken.
    always @(negedge CLK) begin
        if (started) begin
            chk("valid", 32'(valid), 32'(m_armed));
            chk("count", 32'(count), 32'(m_count));
            chk("full", 32'(full), 32'(m_full));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (!RESET && ren && m_armed) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    chk("rdata", 32'(rdata), 32'(sb[0]));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r);
        wen = w; wdata = d; ren = r;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int cyc_n;
        RESET = 1'b1;
        cyc(0, '0, 0);
        cyc(0, '0, 0);
        RESET = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);

        // 1: arm on the eighth write
        for (int i = 0; i < 8; i++) begin
            cyc(1, WIDTH'(16'h1000 + i), 0);
            if (i == 6) chk("s1_valid_7th", 32'(valid), 32'd0);
        end
        chk("s1_valid", 32'(valid), 32'd1);
        chk("s1_count", 32'(count), 32'd8);
        chk("s1_rdata", 32'(rdata), 32'h1000);

        // 2: drain to empty, extra ren ignored
        for (int i = 0; i < 8; i++) cyc(0, '0, 1);
        chk("s2_count", 32'(count), 32'd0);
        chk("s2_valid", 32'(valid), 32'd0);
        cyc(0, '0, 1);
        chk("s2_count_extra", 32'(count), 32'd0);

        // 3: fill completely, dropped write
        for (int i = 0; i < 64; i++) cyc(1, WIDTH'(i), 0);
        cyc(1, 16'hDEAD, 0);
        chk("s3_full", 32'(full), 32'd1);
        chk("s3_count", 32'(count), 32'd64);
        chk("s3_rdata", 32'(rdata), 32'h0000);
`ifdef LBFIFO_RD_OVERFLOW_EN
        chk("s3_ovf", 32'(overflow), 32'd1);
`else
        chk("s3_ovf", 32'(overflow), 32'd0);
`endif

        // 4: push+pop while full
        cyc(1, 16'hBEEF, 1);
        chk("s4_count", 32'(count), 32'd64);
        chk("s4_full", 32'(full), 32'd1);
        for (int i = 0; i < 63; i++) cyc(0, '0, 1);
        chk("s4_last", 32'(rdata), 32'hBEEF);
        cyc(0, '0, 1);
        chk("s4_empty", 32'(count), 32'd0);

        // 5: ren ignored below threshold
        RESET = 1'b1; cyc(0, '0, 0); RESET = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1, WIDTH'(16'h2000 + i), 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1);
        chk("s5_valid", 32'(valid), 32'd0);
        chk("s5_count", 32'(count), 32'd5);
        for (int i = 0; i < 3; i++) cyc(1, WIDTH'(16'h2005 + i), 0);
        chk("s5_valid_arm", 32'(valid), 32'd1);
        chk("s5_rdata", 32'(rdata), 32'h2000);
        for (int i = 0; i < 8; i++) cyc(0, '0, 1);

        // 6: random stream with a mid-stream reset
        nw = 0;
        cyc_n = 0;
        while (nw < 200 && cyc_n < 5000) begin
            if (nw == 100 && !RESET) begin
                RESET = 1'b1;
                cyc(($urandom_range(0, 1) == 1), WIDTH'($urandom), 1);
                RESET = 1'b0;
                nw = 101;
                chk("s6_rst_count", 32'(count), 32'd0);
                chk("s6_rst_valid", 32'(valid), 32'd0);
                chk("s6_rst_full", 32'(full), 32'd0);
                chk("s6_rst_ovf", 32'(overflow), 32'd0);
            end else begin
                cyc(($urandom_range(0, 99) < 70), WIDTH'($urandom),
                    ($urandom_range(0, 99) < 60));
            end
            cyc_n++;
        end
        if (nw < 200) chk("s6_timeout", 32'(nw), 32'd200);
        cyc_n = 0;
        while (m_armed && cyc_n < 200) begin
            cyc(0, '0, 1);
            cyc_n++;
        end
        chk("s6_drained", 32'(m_armed), 32'd0);
        cyc(0, '0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
